// File: rtl/game_display_box_animator.sv
// Battle-box bounds owner: takes resize/move commands and walks each edge toward its target once per frame.
// Latency: command accepted -> 1 LOAD cycle -> edges update the cycle after each frame_tick; done 1 cycle after settling.
// Backpressure: cmd_ready is high only in IDLE; a command held while busy waits until the box has settled.
module game_display_box_animator #(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int BORDER   = 5,
    parameter int MIN_SIZE = 16,
    parameter int DEF_X0   = 220,
    parameter int DEF_Y0   = 240,
    parameter int DEF_X1   = 420,
    parameter int DEF_Y1   = 400
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_x0,
    input  logic [9:0] cmd_y0,
    input  logic [9:0] cmd_x1,
    input  logic [9:0] cmd_y1,
    input  logic [5:0] cmd_step,
    output logic [9:0] game_display_x0,
    output logic [9:0] game_display_y0,
    output logic [9:0] game_display_x1,
    output logic [9:0] game_display_y1,
    output logic       busy,
    output logic       done,
    output logic       cmd_err
);

    localparam logic [9:0]  EDGE_LO = 10'(BORDER);
    localparam logic [9:0]  X_HI    = 10'(H_RES - 1 - BORDER);
    localparam logic [9:0]  Y_HI    = 10'(V_RES - 1 - BORDER);
    localparam logic [10:0] MIN_SZ  = 11'(MIN_SIZE);

    typedef enum logic [1:0] {IDLE, LOAD, MOVE, DONE} state_t;

    state_t     state_q, state_d;
    logic [9:0] raw_x0_q, raw_y0_q, raw_x1_q, raw_y1_q;
    logic [5:0] step_q;
    logic [9:0] tgt_x0_q, tgt_y0_q, tgt_x1_q, tgt_y1_q;
    logic [9:0] x0_q, y0_q, x1_q, y1_q;
    logic       cmd_err_q;

    logic [9:0] cl_x0, cl_y0, cl_x1, cl_y1;
    logic       size_ok;
    logic [9:0] nx0, ny0, nx1, ny1;
    logic       x_inv, y_inv;
    logic [9:0] x0_new, y0_new, x1_new, y1_new;
    logic       at_target;

    function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] hi);
        if (v < EDGE_LO) return EDGE_LO;
        if (v > hi)      return hi;
        return v;
    endfunction

    // One frame of motion for a single edge: never overshoots the target.
    function automatic logic [9:0] approach(input logic [9:0] e, input logic [9:0] t,
                                            input logic [5:0] s);
        logic [10:0] diff;
        if (e == t) return e;
        diff = (e < t) ? ({1'b0, t} - {1'b0, e}) : ({1'b0, e} - {1'b0, t});
        if (s == 6'd0 || diff <= {5'b0, s}) return t;
        return (e < t) ? (e + {4'b0, s}) : (e - {4'b0, s});
    endfunction

    always_comb begin
        cl_x0   = clamp(raw_x0_q, X_HI);
        cl_y0   = clamp(raw_y0_q, Y_HI);
        cl_x1   = clamp(raw_x1_q, X_HI);
        cl_y1   = clamp(raw_y1_q, Y_HI);
        size_ok = ({1'b0, cl_x1} >= {1'b0, cl_x0} + MIN_SZ) &&
                  ({1'b0, cl_y1} >= {1'b0, cl_y0} + MIN_SZ);
    end

    // Proposed step, then hold whichever edge would shrink the box below MIN_SIZE.
    always_comb begin
        nx0    = approach(x0_q, tgt_x0_q, step_q);
        ny0    = approach(y0_q, tgt_y0_q, step_q);
        nx1    = approach(x1_q, tgt_x1_q, step_q);
        ny1    = approach(y1_q, tgt_y1_q, step_q);
        x_inv  = ({1'b0, nx0} + MIN_SZ) > {1'b0, nx1};
        y_inv  = ({1'b0, ny0} + MIN_SZ) > {1'b0, ny1};
        x0_new = (x_inv && nx0 > x0_q) ? x0_q : nx0;
        x1_new = (x_inv && nx1 < x1_q) ? x1_q : nx1;
        y0_new = (y_inv && ny0 > y0_q) ? y0_q : ny0;
        y1_new = (y_inv && ny1 < y1_q) ? y1_q : ny1;
        at_target = (x0_q == tgt_x0_q) && (y0_q == tgt_y0_q) &&
                    (x1_q == tgt_x1_q) && (y1_q == tgt_y1_q);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (cmd_valid) state_d = LOAD;
            LOAD: state_d = size_ok ? MOVE : IDLE;
            MOVE: if (at_target) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_err_q <= (state_q == LOAD) && !size_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_x0_q <= 10'(DEF_X0);
            raw_y0_q <= 10'(DEF_Y0);
            raw_x1_q <= 10'(DEF_X1);
            raw_y1_q <= 10'(DEF_Y1);
            step_q   <= 6'd0;
        end else if (state_q == IDLE && cmd_valid) begin
            raw_x0_q <= cmd_x0;
            raw_y0_q <= cmd_y0;
            raw_x1_q <= cmd_x1;
            raw_y1_q <= cmd_y1;
            step_q   <= cmd_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_x0_q <= 10'(DEF_X0);
            tgt_y0_q <= 10'(DEF_Y0);
            tgt_x1_q <= 10'(DEF_X1);
            tgt_y1_q <= 10'(DEF_Y1);
        end else if (state_q == LOAD && size_ok) begin
            tgt_x0_q <= cl_x0;
            tgt_y0_q <= cl_y0;
            tgt_x1_q <= cl_x1;
            tgt_y1_q <= cl_y1;
        end
    end

    // Edges only change on a frame tick so a displayed frame never sees a half-moved box.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_q <= 10'(DEF_X0);
            y0_q <= 10'(DEF_Y0);
            x1_q <= 10'(DEF_X1);
            y1_q <= 10'(DEF_Y1);
        end else if (state_q == MOVE && frame_tick) begin
            x0_q <= x0_new;
            y0_q <= y0_new;
            x1_q <= x1_new;
            y1_q <= y1_new;
        end
    end

    assign cmd_ready       = (state_q == IDLE);
    assign busy            = (state_q == LOAD) || (state_q == MOVE);
    assign done            = (state_q == DONE);
    assign cmd_err         = cmd_err_q;
    assign game_display_x0 = x0_q;
    assign game_display_y0 = y0_q;
    assign game_display_x1 = x1_q;
    assign game_display_y1 = y1_q;

endmodule
